// File: rtl/led_pattern_ctrl_if.sv
// LED sequencer pin bundle: raw button in, LED drive / mode / step strobe out.
// The controller connects through the slave modport and the driver of the
// button (board top or testbench) through the master modport.
interface led_pattern_ctrl_if;
  logic       btn1;  // raw push button, active-low, asynchronous
  logic [5:0] led;   // active-low LED drive
  logic [1:0] mode;  // current pattern mode
  logic       tick;  // one-cycle step strobe

  modport master (output btn1, input led, mode, tick);
  modport slave  (input btn1, output led, mode, tick);
endinterface

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: 6-LED pattern sequencer.
// A prescaler produces a step tick every WAIT_TIME cycles. The raw button is
// synchronized and debounced, and each debounced press advances the pattern
// mode (CHASE, BOUNCE, FILL, BLINK). Each tick steps the current pattern.
// Optional feature macro: LED_BLINK_EN adds the BLINK mode. Without it the
// mode cycles CHASE -> BOUNCE -> FILL -> CHASE and never reads 3.
module led_pattern_ctrl #(
  parameter int WAIT_TIME       = 13500000,  // cycles per step, >= 2
  parameter int DEBOUNCE_CYCLES = 270000     // stable cycles to accept, >= 1
) (
  input  logic                clk,
  input  logic                rst,
  led_pattern_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(WAIT_TIME);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIME - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    CHASE  = 2'd0,
    BOUNCE = 2'd1,
    FILL   = 2'd2,
    BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Prescaler
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Button synchronizer and debouncer
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;          // debounced level, 1 = released
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             press;               // debounced released->pressed pulse

  // Pattern state
  mode_e            mode_q, mode_d;
  logic [5:0]       led_val_q, led_val_d;
  dir_e             dir_q, dir_d;

  // Mode that follows the current one on a press.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      CHASE:   return BOUNCE;
      BOUNCE:  return FILL;
`ifdef LED_BLINK_EN
      FILL:    return BLINK;
`else
      FILL:    return CHASE;
`endif
      default: return CHASE;
    endcase
  endfunction

  // Prescaler: count 0..WAIT_TIME-1, restart from 0 on a press so the new
  // mode's first step comes a full period later; tick mirrors count==last.
  always_comb begin
    // NOTE: every _d is given a default before any branch, so no path can
    // leave it unassigned and no latch is inferred.
    cnt_d = cnt_q + CNT_W'(1);
    if (press || cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
    tick_d = (cnt_d == CNT_LAST);
  end

  // Debouncer: count consecutive cycles the synced button disagrees with the
  // debounced level; flip after DEBOUNCE_CYCLES and flag only the press edge.
  always_comb begin
    // Two-stage synchronizer on the asynchronous pin.
    sync1_d  = bus.btn1;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_cnt_d = '0;
    press    = 1'b0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d  = sync2_q;
        press = ~sync2_q;  // flipping to 0 means newly pressed
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Mode FSM and pattern stepping; a press reloads the new mode's start value
  // and discards any tick that lands on the same cycle.
  always_comb begin
    mode_d    = mode_q;
    led_val_d = led_val_q;
    dir_d     = dir_q;
    if (press) begin
      mode_d = next_mode(mode_q);
      dir_d  = DIR_LEFT;
      case (next_mode(mode_q))
        CHASE, BOUNCE: led_val_d = 6'b000001;
        default:       led_val_d = 6'b000000;
      endcase
    end else if (tick_q) begin
      case (mode_q)
        CHASE: led_val_d = {led_val_q[4:0], led_val_q[5]};
        BOUNCE: begin
          if (dir_q == DIR_LEFT) begin
            if (led_val_q == 6'b100000) begin
              dir_d     = DIR_RIGHT;
              led_val_d = 6'b010000;
            end else begin
              led_val_d = led_val_q << 1;
            end
          end else begin
            if (led_val_q == 6'b000001) begin
              dir_d     = DIR_LEFT;
              led_val_d = 6'b000010;
            end else begin
              led_val_d = led_val_q >> 1;
            end
          end
        end
        FILL: begin
          if (led_val_q == 6'b111111) begin
            led_val_d = 6'b000000;
          end else begin
            led_val_d = {led_val_q[4:0], 1'b1};
          end
        end
`ifdef LED_BLINK_EN
        BLINK: led_val_d = ~led_val_q;
`endif
        default: led_val_d = led_val_q;
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignment so every register updates from
    // the values present before the edge, independent of statement order.
    if (rst) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      db_q      <= 1'b1;
      db_cnt_q  <= '0;
      mode_q    <= CHASE;
      led_val_q <= 6'b000001;
      dir_q     <= DIR_LEFT;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_cnt_q  <= db_cnt_d;
      mode_q    <= mode_d;
      led_val_q <= led_val_d;
      dir_q     <= dir_d;
    end
  end

  assign bus.led  = ~led_val_q;
  assign bus.mode = mode_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed testbench for led_pattern_ctrl with WAIT_TIME=4, DEBOUNCE_CYCLES=3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_led_pattern_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  led_pattern_ctrl_if bus_if ();

  led_pattern_ctrl #(
    .WAIT_TIME       (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Bound the whole run in case something stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Active-low drive expected for a given internal pattern value.
  function automatic logic [5:0] led_of(input logic [5:0] v);
    return ~v;
  endfunction

  // Hold the button from now, expect the mode to advance on the 4th edge
  // after the first low sample, with the new mode's start pattern.
  task automatic press_mode(input int from_m, input int to_m, input logic [5:0] start_v);
    bus_if.btn1 = 1'b0;
    repeat (4) step();
    check("press_before", int'(bus_if.mode), from_m);
    step();
    check("press_mode", int'(bus_if.mode), to_m);
    check("press_led", int'(bus_if.led), int'(led_of(start_v)));
    bus_if.btn1 = 1'b1;
  endtask

  int bounce_seq[12] = '{2, 4, 8, 16, 32, 16, 8, 4, 2, 1, 2, 4};
  int fill_seq[7]    = '{1, 3, 7, 15, 31, 63, 0};

  initial begin
    logic [5:0] ev;
    rst         = 1'b1;
    bus_if.btn1 = 1'b1;
    repeat (3) step();
    check("rst_led",  int'(bus_if.led),  int'(6'b111110));
    check("rst_mode", int'(bus_if.mode), 0);
    check("rst_tick", int'(bus_if.tick), 0);
    rst = 1'b0;

    // CHASE free run: tick in the 4th cycle of each period, rotate each period.
    for (int k = 1; k <= 30; k++) begin
      step();
      ev = 6'd1 << ((k / 4) % 6);
      check("chase_tick", int'(bus_if.tick), int'(k % 4 == 3));
      check("chase_led",  int'(bus_if.led),  int'(led_of(ev)));
    end

    // Held press: advance to BOUNCE on the 4th edge after first low sample.
    bus_if.btn1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_wait_mode", int'(bus_if.mode), 0);
    end
    step();
    check("hold_mode", int'(bus_if.mode), 1);
    check("hold_led",  int'(bus_if.led),  int'(6'b111110));
    check("hold_tick", int'(bus_if.tick), 0);
    repeat (3) step();
    check("bounce_first_tick", int'(bus_if.tick), 1);
    check("bounce_hold_led",   int'(bus_if.led),  int'(6'b111110));

    // BOUNCE for 12 ticks with the button still held: no second advance.
    for (int j = 0; j < 12; j++) begin
      if (j == 0) step(); else repeat (4) step();
      check("bounce_led",  int'(bus_if.led),  int'(led_of(6'(bounce_seq[j]))));
      check("bounce_mode", int'(bus_if.mode), 1);
    end

    // Release, then a 2-cycle glitch must not change the mode.
    bus_if.btn1 = 1'b1;
    repeat (8) step();
    check("release_mode", int'(bus_if.mode), 1);
    bus_if.btn1 = 1'b0;
    repeat (2) step();
    bus_if.btn1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("glitch_mode", int'(bus_if.mode), 1);
    end

    // Reset mid-BOUNCE with the debounce counter at 2.
    bus_if.btn1 = 1'b0;
    repeat (4) step();
    check("pre_rst_mode", int'(bus_if.mode), 1);
    rst = 1'b1;
    step();
    check("mid_rst_led",  int'(bus_if.led),  int'(6'b111110));
    check("mid_rst_mode", int'(bus_if.mode), 0);
    check("mid_rst_tick", int'(bus_if.tick), 0);
    rst         = 1'b0;
    bus_if.btn1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_mode", int'(bus_if.mode), 0);
    end
    check("post_rst_tick", int'(bus_if.tick), 1);

    // Press timed so the debounce flip lands on a tick cycle.
    bus_if.btn1 = 1'b0;
    step();
    check("coinc_pre_led", int'(bus_if.led), int'(led_of(6'd2)));
    repeat (3) step();
    check("coinc_pre_tick", int'(bus_if.tick), 1);
    check("coinc_pre_mode", int'(bus_if.mode), 0);
    step();
    check("coinc_mode", int'(bus_if.mode), 1);
    check("coinc_led",  int'(bus_if.led),  int'(led_of(6'd1)));
    check("coinc_tick", int'(bus_if.tick), 0);
    bus_if.btn1 = 1'b1;
    repeat (3) step();
    check("coinc_next_tick", int'(bus_if.tick), 1);
    check("coinc_next_hold", int'(bus_if.led),  int'(led_of(6'd1)));
    step();
    check("coinc_next_led",  int'(bus_if.led),  int'(led_of(6'd2)));
    repeat (2) step();

    // Second press: FILL and its 7-step cycle.
    press_mode(1, 2, 6'd0);
    for (int j = 0; j < 7; j++) begin
      repeat (4) step();
      check("fill_led", int'(bus_if.led), int'(led_of(6'(fill_seq[j]))));
    end

    // Third press: BLINK when enabled, otherwise back to CHASE.
`ifdef LED_BLINK_EN
    press_mode(2, 3, 6'd0);
    repeat (4) step();
    check("blink_led_on",  int'(bus_if.led), int'(led_of(6'd63)));
    repeat (4) step();
    check("blink_led_off", int'(bus_if.led), int'(led_of(6'd0)));
`else
    press_mode(2, 0, 6'd1);
    repeat (4) step();
    check("wrap_chase_led1", int'(bus_if.led), int'(led_of(6'd2)));
    repeat (4) step();
    check("wrap_chase_led2", int'(bus_if.led), int'(led_of(6'd4)));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
